// File: rtl/ufc_bridge_pkg.sv
// Shared definitions for the multi-channel FIFO-over-UFC bridge: beat tag layout,
// TX FSM state encoding and the UFC message-size helper.
package ufc_bridge_pkg;

  localparam logic [3:0] TAG_MARK = 4'hC;
  localparam int         TAG_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_REQ  = 3'd2,
    ST_WLO  = 3'd3,
    ST_WHI  = 3'd4,
    ST_SEND = 3'd5
  } tx_state_t;

  // UFC message size field: bytes in the message minus one
  function automatic logic [7:0] ms_bytes(input int unsigned beats, input int unsigned adw);
    int unsigned b;
    b = beats * (adw / 8) - 1;
    return b[7:0];
  endfunction

endpackage

// File: rtl/fifo_over_ufc_mc_if.sv
// Aurora UFC user-side signals of the bridge. master = bridge, slave = Aurora core.
interface fifo_over_ufc_mc_if #(
  parameter int ADW = 64
);
  // TX: REQ is a one-cycle pulse carrying MS; afterwards a beat transfers on every
  // cycle where TVALID and TREADY are both high, TDATA held stable while TVALID && !TREADY.
  // RX: a beat transfers on every cycle with RX_TVALID high; there is no backpressure.
  logic           AURORA_TX_REQ;
  logic [7:0]     AURORA_TX_MS;
  logic           AURORA_TX_TREADY;
  logic [ADW-1:0] AURORA_TX_TDATA;
  logic           AURORA_TX_TVALID;
  logic [ADW-1:0] AURORA_RX_TDATA;
  logic           AURORA_RX_TVALID;

  modport master (
    output AURORA_TX_REQ, AURORA_TX_MS, AURORA_TX_TDATA, AURORA_TX_TVALID,
    input  AURORA_TX_TREADY, AURORA_RX_TDATA, AURORA_RX_TVALID
  );

  modport slave (
    input  AURORA_TX_REQ, AURORA_TX_MS, AURORA_TX_TDATA, AURORA_TX_TVALID,
    output AURORA_TX_TREADY, AURORA_RX_TDATA, AURORA_RX_TVALID
  );
endinterface

// File: rtl/ufc_rr_arbiter.sv
// Round-robin channel picker: first requesting channel at or after the pointer,
// wrapping around. Purely combinational; the pointer register lives in the caller.
module ufc_rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0] i_req,
  input  logic [IW-1:0]  i_ptr,
  output logic [NCH-1:0] o_gnt,
  output logic [IW-1:0]  o_idx,
  output logic           o_any
);

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int off = 0; off < NCH; off++) begin
      if (!o_any && i_req[(int'(i_ptr) + off) % NCH]) begin
        o_any = 1'b1;
        o_gnt[(int'(i_ptr) + off) % NCH] = 1'b1;
        o_idx = IW'((int'(i_ptr) + off) % NCH);
      end
    end
  end

endmodule

// File: rtl/fifo_over_ufc_mc.sv
// Multi-channel FIFO bridge over one Aurora UFC link: TX bursts from per-channel read
// FIFOs with round-robin arbitration, RX demux of tagged beats into per-channel write FIFOs.
module fifo_over_ufc_mc
  import ufc_bridge_pkg::*;
#(
  parameter int NCH               = 4,
  parameter int FIFO_DATA_WIDTH   = 32,
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int MAX_BURST         = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  fifo_over_ufc_mc_if.master             aur,
  output logic                           FIFO_CLK,
  output logic [NCH*FIFO_DATA_WIDTH-1:0] TX_FIFO_Q,
  output logic [NCH-1:0]                 TX_FIFO_WREN,
  input  logic [NCH-1:0]                 TX_FIFO_FULL,
  input  logic [NCH*FIFO_DATA_WIDTH-1:0] RX_FIFO_Q,
  output logic [NCH-1:0]                 RX_FIFO_RDEN,
  input  logic [NCH-1:0]                 RX_FIFO_EMPTY,
  input  logic                           ERR_CLR,
  output logic [1:0]                     ERR,
  output tx_state_t                      o_dbg_state
);

  localparam int FDW = FIFO_DATA_WIDTH;
  localparam int ADW = AURORA_DATA_WIDTH;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = $clog2(MAX_BURST + 1);
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  tx_state_t        r_state, w_state_n;
  logic [IW-1:0]    r_ch, r_ptr, w_gnt_idx;
  logic [NCH-1:0]   r_ch_oh, w_gnt;
  logic             w_any, w_pop, w_last, w_empty;
  logic [CW-1:0]    r_cnt, r_idx;
  logic [FDW-1:0]   r_buf [MAX_BURST];
  logic [FDW-1:0]   w_head;
  logic [ADW-1:0]   w_beat;

  ufc_rr_arbiter #(.NCH(NCH), .IW(IW)) u_arb (
    .i_req (~RX_FIFO_EMPTY),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_gnt_idx),
    .o_any (w_any)
  );

  assign w_head  = RX_FIFO_Q[int'(r_ch)*FDW +: FDW];
  assign w_empty = RX_FIFO_EMPTY[r_ch];

  always_comb begin
    w_state_n = r_state;
    w_pop     = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      ST_IDLE: if (w_any) w_state_n = ST_FILL;
      ST_FILL: begin
        w_pop = !w_empty;
        if (w_pop && (r_cnt == CW'(MAX_BURST - 1))) w_state_n = ST_REQ;
        else if (w_empty)                           w_state_n = ST_REQ;
      end
      ST_REQ:  w_state_n = ST_WLO;
      // A low TREADY after REQ marks the UFC slot opening; data goes once it returns high
      ST_WLO:  if (!aur.AURORA_TX_TREADY) w_state_n = ST_WHI;
      ST_WHI:  if (aur.AURORA_TX_TREADY)  w_state_n = ST_SEND;
      ST_SEND: begin
        if (aur.AURORA_TX_TREADY) begin
          w_last = (r_idx == r_cnt - 1'b1);
          if (w_last) w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ch    <= '0;
      r_ch_oh <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      for (int i = 0; i < MAX_BURST; i++) r_buf[i] <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any) begin
        r_ch    <= w_gnt_idx;
        r_ch_oh <= w_gnt;
        r_cnt   <= '0;
        r_idx   <= '0;
      end
      if (w_pop) begin
        r_buf[r_cnt[BW-1:0]] <= w_head;
        r_cnt                <= r_cnt + 1'b1;
      end
      if (r_state == ST_SEND && aur.AURORA_TX_TREADY) begin
        if (w_last) begin
          r_idx <= '0;
          r_ptr <= (r_ch == IW'(NCH - 1)) ? '0 : r_ch + 1'b1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_beat                    = '0;
    w_beat[ADW-1 -: TAG_W]    = {TAG_MARK, 4'(r_ch)};
    w_beat[FDW-1:0]           = r_buf[r_idx[BW-1:0]];
  end

  assign aur.AURORA_TX_REQ    = (r_state == ST_REQ);
  assign aur.AURORA_TX_MS     = (r_state == ST_REQ) ? ms_bytes(32'(r_cnt), ADW) : 8'h00;
  assign aur.AURORA_TX_TVALID = (r_state == ST_SEND);
  assign aur.AURORA_TX_TDATA  = (r_state == ST_SEND) ? w_beat : '0;
  assign RX_FIFO_RDEN         = w_pop ? r_ch_oh : '0;
  assign FIFO_CLK             = clk;
  assign o_dbg_state          = r_state;

  // RX demux: tag decoded in the arrival cycle, write issued one cycle later
  logic [TAG_W-1:0] w_tag;
  logic [3:0]       w_rx_ch;
  logic [NCH-1:0]   w_rx_oh, r_wren;
  logic             w_tag_ok, w_full, w_rx_wr, w_rx_bad, w_rx_drop;
  logic [NCH*FDW-1:0] r_wq;
  logic [1:0]       r_err;

  assign w_tag    = aur.AURORA_RX_TDATA[ADW-1 -: TAG_W];
  assign w_rx_ch  = w_tag[3:0];
  assign w_tag_ok = (w_tag[7:4] == TAG_MARK) && (32'(w_rx_ch) < 32'(NCH));

  always_comb begin
    w_rx_oh = '0;
    w_full  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (w_rx_ch == 4'(i)) begin
        w_rx_oh[i] = 1'b1;
        w_full     = TX_FIFO_FULL[i];
      end
    end
  end

  assign w_rx_wr   = aur.AURORA_RX_TVALID &&  w_tag_ok && !w_full;
  assign w_rx_drop = aur.AURORA_RX_TVALID &&  w_tag_ok &&  w_full;
  assign w_rx_bad  = aur.AURORA_RX_TVALID && !w_tag_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wren <= '0;
      r_wq   <= '0;
      r_err  <= 2'b00;
    end else begin
      r_wren <= w_rx_wr ? w_rx_oh : '0;
      for (int i = 0; i < NCH; i++) begin
        if (w_rx_wr && w_rx_oh[i]) r_wq[i*FDW +: FDW] <= aur.AURORA_RX_TDATA[FDW-1:0];
      end
      // a new error event wins over a clear in the same cycle
      r_err[0] <= w_rx_drop | (r_err[0] & ~ERR_CLR);
      r_err[1] <= w_rx_bad  | (r_err[1] & ~ERR_CLR);
    end
  end

  assign TX_FIFO_WREN = r_wren;
  assign TX_FIFO_Q    = r_wq;
  assign ERR          = r_err;

endmodule

// File: tb/tb_fifo_over_ufc_mc.sv
// Self-checking bench for fifo_over_ufc_mc: FIFO source models, a UFC TX responder,
// RX beat driver and per-scenario checks against expected queues.
module tb_fifo_over_ufc_mc;
  import ufc_bridge_pkg::*;

  localparam int NCH = 4;
  localparam int FDW = 32;
  localparam int ADW = 64;
  localparam int MB  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_over_ufc_mc_if #(.ADW(ADW)) aur();

  logic                 fifo_clk;
  logic [NCH*FDW-1:0]   tx_q;
  logic [NCH-1:0]       tx_wren;
  logic [NCH-1:0]       tx_full = '0;
  logic [NCH*FDW-1:0]   rx_q = '0;
  logic [NCH-1:0]       rx_rden;
  logic [NCH-1:0]       rx_empty = '1;
  logic                 err_clr = 1'b0;
  logic [1:0]           err;
  tx_state_t            dbg;

  fifo_over_ufc_mc #(
    .NCH(NCH), .FIFO_DATA_WIDTH(FDW), .AURORA_DATA_WIDTH(ADW), .MAX_BURST(MB)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .aur           (aur),
    .FIFO_CLK      (fifo_clk),
    .TX_FIFO_Q     (tx_q),
    .TX_FIFO_WREN  (tx_wren),
    .TX_FIFO_FULL  (tx_full),
    .RX_FIFO_Q     (rx_q),
    .RX_FIFO_RDEN  (rx_rden),
    .RX_FIFO_EMPTY (rx_empty),
    .ERR_CLR       (err_clr),
    .ERR           (err),
    .o_dbg_state   (dbg)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // scoreboards
  logic [ADW-1:0]   exp_q[$];
  logic [ADW-1:0]   got_q[$];
  logic [FDW+3:0]   rx_exp_q[$];
  logic [7:0]       got_ms;
  bit               got_to, got_wide;

  // FWFT source FIFO models feeding RX_FIFO_*
  logic [FDW-1:0]   src_q[NCH][$];
  int               rden_cnt[NCH];
  int               underflow = 0;
  logic [NCH-1:0]   m_pops;

  initial for (int i = 0; i < NCH; i++) rden_cnt[i] = 0;

  always @(posedge clk) begin
    m_pops = rx_rden;
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (m_pops[i]) begin
        rden_cnt[i]++;
        if (src_q[i].size() == 0) underflow++;
        else void'(src_q[i].pop_front());
      end
      rx_empty[i] = (src_q[i].size() == 0);
      rx_q[i*FDW +: FDW] = (src_q[i].size() == 0) ? '0 : src_q[i][0];
    end
  end

  function automatic logic [ADW-1:0] mk_beat(input logic [7:0] tag, input logic [FDW-1:0] w);
    logic [ADW-1:0] b;
    b = '0;
    b[ADW-1 -: 8] = tag;
    b[FDW-1:0] = w;
    return b;
  endfunction

  // driver tasks
  task automatic push_word(input int ch, input logic [FDW-1:0] w, input bit expect_tx);
    src_q[ch].push_back(w);
    if (expect_tx) exp_q.push_back(mk_beat({4'hC, 4'(ch)}, w));
  endtask

  task automatic rx_drive(input bit v, input logic [7:0] tag, input logic [FDW-1:0] d);
    aur.AURORA_RX_TVALID = v;
    aur.AURORA_RX_TDATA  = v ? mk_beat(tag, d) : '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    aur.AURORA_TX_TREADY = 1'b1;
    rx_drive(1'b0, 8'h00, '0);
    tx_full = '0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  // UFC TX responder: waits for REQ, holds TREADY low two cycles, collects beats
  task automatic ufc_serve();
    int t;
    bit seen;
    got_to = 1'b0; got_wide = 1'b0; got_ms = '0; got_q.delete();
    t = 0;
    while (aur.AURORA_TX_REQ !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin got_to = 1'b1; return; end
    got_ms = aur.AURORA_TX_MS;
    aur.AURORA_TX_TREADY = 1'b0;
    @(negedge clk);
    if (aur.AURORA_TX_REQ !== 1'b0) got_wide = 1'b1;
    @(negedge clk);
    aur.AURORA_TX_TREADY = 1'b1;
    seen = 1'b0;
    t = 0;
    while (t < 40) begin
      @(negedge clk);
      t++;
      if (aur.AURORA_TX_TVALID === 1'b1) begin got_q.push_back(aur.AURORA_TX_TDATA); seen = 1'b1; end
      else if (seen) break;
    end
    if (!seen) got_to = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    aur.AURORA_TX_TREADY = 1'b1;
    rx_drive(1'b0, 8'h00, '0);
    repeat (2) @(negedge clk);
    n_chk++; if ({aur.AURORA_TX_REQ, aur.AURORA_TX_MS, aur.AURORA_TX_TVALID} !== 10'd0)
      $display("FAIL rst_tx_ctl: got %h want 0", {aur.AURORA_TX_REQ, aur.AURORA_TX_MS, aur.AURORA_TX_TVALID});
    else n_pass++;
    n_chk++; if (aur.AURORA_TX_TDATA !== '0) $display("FAIL rst_tdata: got %h want 0", aur.AURORA_TX_TDATA);
    else n_pass++;
    n_chk++; if ({tx_wren, rx_rden, err} !== '0) $display("FAIL rst_wren_rden_err: got %h want 0", {tx_wren, rx_rden, err});
    else n_pass++;
    n_chk++; if (tx_q !== '0) $display("FAIL rst_txq: got %h want 0", tx_q);
    else n_pass++;
    n_chk++; if (dbg !== ST_IDLE) $display("FAIL rst_state: got %0d want %0d", dbg, ST_IDLE);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_word();
    int r0;
    r0 = rden_cnt[2];
    @(negedge clk);
    push_word(2, 32'hDEADBEEF, 1'b1);
    ufc_serve();
    n_chk++; if (got_to || got_ms !== 8'd7) $display("FAIL t1_ms: got %0d (timeout %0d) want 7", got_ms, got_to);
    else n_pass++;
    n_chk++; if (got_wide) $display("FAIL t1_req_pulse: got wide pulse want 1 cycle");
    else n_pass++;
    n_chk++; if (got_q.size() != 1 || got_q[0] !== 64'hC200_0000_DEAD_BEEF)
      $display("FAIL t1_beat: got %0d beats first %h want 1 beat c2000000deadbeef", got_q.size(), got_q.size() ? got_q[0] : '0);
    else n_pass++;
    void'(exp_q.pop_front());
    n_chk++; if (rden_cnt[2] - r0 != 1) $display("FAIL t1_rden: got %0d pops want 1", rden_cnt[2] - r0);
    else n_pass++;
  endtask

  task automatic test_burst_split();
    int r0;
    logic [ADW-1:0] e;
    logic [7:0] exp_ms[2];
    int exp_n[2];
    exp_ms[0] = 8'd31; exp_n[0] = 4;
    exp_ms[1] = 8'd15; exp_n[1] = 2;
    r0 = rden_cnt[0];
    @(negedge clk);
    for (int k = 0; k < 6; k++) push_word(0, $urandom(), 1'b1);
    for (int m = 0; m < 2; m++) begin
      ufc_serve();
      n_chk++; if (got_to || got_ms !== exp_ms[m]) $display("FAIL t2_ms%0d: got %0d want %0d", m, got_ms, exp_ms[m]);
      else n_pass++;
      n_chk++; if (got_q.size() != exp_n[m]) $display("FAIL t2_nbeats%0d: got %0d want %0d", m, got_q.size(), exp_n[m]);
      else n_pass++;
      for (int k = 0; k < exp_n[m]; k++) begin
        e = exp_q.pop_front();
        n_chk++; if (k >= got_q.size() || got_q[k] !== e)
          $display("FAIL t2_beat%0d_%0d: got %h want %h", m, k, (k < got_q.size()) ? got_q[k] : '0, e);
        else n_pass++;
      end
    end
    n_chk++; if (rden_cnt[0] - r0 != 6) $display("FAIL t2_rden: got %0d pops want 6", rden_cnt[0] - r0);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [ADW-1:0] e;
    apply_reset();
    push_word(0, 32'hA0A0_0000, 1'b1);
    push_word(1, 32'hB1B1_1111, 1'b1);
    push_word(3, 32'hD3D3_3333, 1'b1);
    for (int m = 0; m < 4; m++) begin
      ufc_serve();
      if (m == 0) push_word(0, 32'hA0A0_0001, 1'b1);
      e = exp_q.pop_front();
      n_chk++; if (got_to || got_ms !== 8'd7 || got_q.size() != 1 || got_q[0] !== e)
        $display("FAIL t3_msg%0d: got ms %0d beat %h want ms 7 beat %h", m, got_ms, got_q.size() ? got_q[0] : '0, e);
      else n_pass++;
    end
  endtask

  task automatic test_rx_demux();
    logic [7:0]     tags[8];
    logic [FDW-1:0] pays[8];
    logic [FDW+3:0] e;
    tags[0] = 8'hC1; pays[0] = 32'h1111_AAAA;
    tags[1] = 8'hC3; pays[1] = 32'h3333_BBBB;
    for (int k = 2; k < 8; k++) begin
      tags[k] = {4'hC, 4'($urandom_range(0, NCH - 1))};
      pays[k] = $urandom();
    end
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (rx_exp_q.size() > 0) begin
        e = rx_exp_q.pop_front();
        n_chk++; if (tx_wren !== (4'b0001 << e[FDW+3:FDW]) || tx_q[int'(e[FDW+3:FDW])*FDW +: FDW] !== e[FDW-1:0])
          $display("FAIL rx_write%0d: got wren %b data %h want ch %0d data %h", k, tx_wren,
                   tx_q[int'(e[FDW+3:FDW])*FDW +: FDW], e[FDW+3:FDW], e[FDW-1:0]);
        else n_pass++;
      end else begin
        n_chk++; if (tx_wren !== '0) $display("FAIL rx_idle%0d: got wren %b want 0", k, tx_wren);
        else n_pass++;
      end
      if (k < 8) begin
        rx_drive(1'b1, tags[k], pays[k]);
        rx_exp_q.push_back({tags[k][3:0], pays[k]});
      end else begin
        rx_drive(1'b0, 8'h00, '0);
      end
    end
    @(negedge clk);
    n_chk++; if (err !== 2'b00 || tx_wren !== '0) $display("FAIL rx_clean: got err %b wren %b want 00 0000", err, tx_wren);
    else n_pass++;
  endtask

  task automatic test_rx_errors();
    logic [1:0] exp_err[5];
    exp_err[0] = 2'b01; exp_err[1] = 2'b11; exp_err[2] = 2'b00; exp_err[3] = 2'b10; exp_err[4] = 2'b00;
    @(negedge clk);
    tx_full = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      case (k)
        0: begin rx_drive(1'b1, 8'hC1, 32'h0BAD_0001); err_clr = 1'b0; end
        1: begin rx_drive(1'b1, 8'hC7, 32'h0BAD_0007); err_clr = 1'b0; end
        2: begin rx_drive(1'b0, 8'h00, '0);            err_clr = 1'b1; end
        3: begin rx_drive(1'b1, 8'h51, 32'h0BAD_0051); err_clr = 1'b1; end
        default: begin rx_drive(1'b0, 8'h00, '0);      err_clr = 1'b1; end
      endcase
      @(negedge clk);
      n_chk++; if (err !== exp_err[k] || tx_wren !== '0)
        $display("FAIL rx_err%0d: got err %b wren %b want err %b wren 0", k, err, tx_wren, exp_err[k]);
      else n_pass++;
    end
    err_clr = 1'b0;
    tx_full = '0;
  endtask

  task automatic test_reset_mid_message();
    int t;
    logic [ADW-1:0] e;
    @(negedge clk);
    for (int k = 0; k < 3; k++) push_word(2, 32'hEE00_0000 + k, 1'b0);
    t = 0;
    while (aur.AURORA_TX_REQ !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    n_chk++; if (t >= 100 || aur.AURORA_TX_MS !== 8'd23) $display("FAIL t6_ms: got %0d (waited %0d) want 23", aur.AURORA_TX_MS, t);
    else n_pass++;
    aur.AURORA_TX_TREADY = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (dbg !== ST_WHI) $display("FAIL t6_in_whi: got %0d want %0d", dbg, ST_WHI);
    else n_pass++;
    push_word(2, 32'hEE00_0003, 1'b1);
    push_word(2, 32'hEE00_0004, 1'b1);
    rx_drive(1'b1, 8'hC0, 32'h5555_0000);
    @(negedge clk);
    rx_drive(1'b0, 8'h00, '0);
    n_chk++; if (tx_wren !== 4'b0001) $display("FAIL t6_pre_wren: got %b want 0001", tx_wren);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_chk++; if ({aur.AURORA_TX_REQ, aur.AURORA_TX_TVALID, tx_wren, rx_rden, err} !== '0 || dbg !== ST_IDLE)
      $display("FAIL t6_async_rst: got req %b tvalid %b wren %b rden %b state %0d want all 0",
               aur.AURORA_TX_REQ, aur.AURORA_TX_TVALID, tx_wren, rx_rden, dbg);
    else n_pass++;
    @(negedge clk);
    n_chk++; if (aur.AURORA_TX_TDATA !== '0 || tx_q !== '0) $display("FAIL t6_rst_data: got %h %h want 0", aur.AURORA_TX_TDATA, tx_q);
    else n_pass++;
    @(negedge clk);
    aur.AURORA_TX_TREADY = 1'b1;
    reset = 1'b0;
    ufc_serve();
    n_chk++; if (got_to || got_ms !== 8'd15 || got_q.size() != 2) $display("FAIL t6_resume: got ms %0d beats %0d want 15 2", got_ms, got_q.size());
    else n_pass++;
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      n_chk++; if (k >= got_q.size() || got_q[k] !== e) $display("FAIL t6_beat%0d: got %h want %h", k, (k < got_q.size()) ? got_q[k] : '0, e);
      else n_pass++;
    end
    n_chk++; if (underflow != 0 || exp_q.size() != 0) $display("FAIL tb_pops: got underflow %0d leftover %0d want 0 0", underflow, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_word();
    test_burst_split();
    test_round_robin();
    test_rx_demux();
    test_rx_errors();
    test_reset_mid_message();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
